// File: rtl/image_buffer_pkg.sv
// Shared types and constants for the image buffer controller and its word packer.
package image_buffer_pkg;

    localparam int WORD_ADDRESS_WIDTH = 14;
    localparam int MAX_FRAME_BYTES    = 65536;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/image_buffer_word_packer.sv
// Packs captured bytes little-endian into 32-bit words, counts bytes, flags overflow
// and holds the single-cycle write_pending word for the LRAM port.
module image_buffer_word_packer
    import image_buffer_pkg::*;
#(
    parameter int BYTE_ADDRESS_WIDTH = WORD_ADDRESS_WIDTH + 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          capture_i,
    input  logic                          pixel_valid_i,
    input  logic [7:0]                    pixel_data_i,
    input  logic                          frame_end_i,
    output logic [BYTE_ADDRESS_WIDTH:0]   count_o,
    output logic                          overflow_o,
    output logic                          pending_o,
    output logic                          pending_next_o,
    output logic [BYTE_ADDRESS_WIDTH-3:0] pending_addr_o,
    output logic [31:0]                   pending_data_o
);

    localparam int BAW = BYTE_ADDRESS_WIDTH;
    localparam logic [BAW:0] CNT_ONE = {{BAW{1'b0}}, 1'b1};

    logic [BAW:0]   count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [31:0]    word_q, word_d, merged;
    logic           pend_q, pend_d;
    logic [BAW-3:0] pend_addr_q, pend_addr_d;
    logic [31:0]    pend_data_q, pend_data_d;
    logic [1:0]     lane;
    logic           accept;

    assign lane = count_q[1:0];

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        word_d      = word_q;
        merged      = word_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        accept      = 1'b0;
        if (clear_i) begin
            count_d    = '0;
            overflow_d = 1'b0;
            word_d     = '0;
        end else if (capture_i) begin
            if (pixel_valid_i) begin
                // The count saturates at exactly 2^BAW bytes; its top bit marks a full frame.
                if (count_q[BAW]) begin
                    overflow_d = 1'b1;
                end else begin
                    accept = 1'b1;
                    merged[{lane, 3'b000} +: 8] = pixel_data_i;
                    count_d = count_q + CNT_ONE;
                    word_d  = merged;
                end
            end
            if ((accept && lane == 2'd3) || (frame_end_i && count_d[1:0] != 2'd0)) begin
                pend_d      = 1'b1;
                pend_addr_d = count_q[BAW-1:2];
                pend_data_d = merged;
                word_d      = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign pending_o      = pend_q;
    assign pending_next_o = pend_d;
    assign pending_addr_o = pend_addr_q;
    assign pending_data_o = pend_data_q;

endmodule

// File: rtl/image_buffer_controller.sv
// Frame capture sequencer and single-port LRAM arbiter: pending capture writes always
// win the address port, host byte reads use every remaining cycle.
module image_buffer_controller
    import image_buffer_pkg::*;
#(
    parameter int BYTE_ADDRESS_WIDTH = WORD_ADDRESS_WIDTH + 2
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic                          capture_start_in,
    input  logic                          pixel_valid_in,
    input  logic [7:0]                    pixel_data_in,
    input  logic                          frame_end_in,
    output logic                          capture_busy_out,
    output logic                          capture_done_out,
    output logic [BYTE_ADDRESS_WIDTH:0]   captured_bytes_out,
    output logic                          overflow_out,
    input  logic                          read_request_valid_in,
    input  logic [BYTE_ADDRESS_WIDTH-1:0] read_request_address_in,
    output logic                          read_request_ready_out,
    output logic                          read_data_valid_out,
    output logic [7:0]                    read_data_out,
    output logic [BYTE_ADDRESS_WIDTH-3:0] ram_address_out,
    output logic [31:0]                   ram_write_data_out,
    output logic                          ram_write_enable_out,
    input  logic [31:0]                   ram_read_data_in
);

    state_e state_q, state_d;
    logic   start_ok, capturing, pending, pending_next, rd_accept;
    logic [BYTE_ADDRESS_WIDTH-3:0] pending_addr;

    logic       rd_vld_p0_q, rd_vld_p1_q;
    logic [1:0] rd_lane_p0_q, rd_lane_d;
    logic [7:0] rd_data_p1_q, rd_data_d;

    assign start_ok  = capture_start_in && (state_q == ST_IDLE || state_q == ST_DONE);
    assign capturing = (state_q == ST_CAPTURE);

    image_buffer_word_packer #(
        .BYTE_ADDRESS_WIDTH(BYTE_ADDRESS_WIDTH)
    ) u_packer (
        .clk_i          (clock_in),
        .rst_i          (reset_in),
        .clear_i        (start_ok),
        .capture_i      (capturing),
        .pixel_valid_i  (pixel_valid_in),
        .pixel_data_i   (pixel_data_in),
        .frame_end_i    (frame_end_in),
        .count_o        (captured_bytes_out),
        .overflow_o     (overflow_out),
        .pending_o      (pending),
        .pending_next_o (pending_next),
        .pending_addr_o (pending_addr),
        .pending_data_o (ram_write_data_out)
    );

    // FLUSH lasts only while the final word is being written, so DONE is reached
    // one cycle after frame end when nothing is left to write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_ok) state_d = ST_CAPTURE;
            ST_CAPTURE: if (frame_end_in) state_d = pending_next ? ST_FLUSH : ST_DONE;
            ST_FLUSH:   if (!pending_next) state_d = ST_DONE;
            ST_DONE:    if (start_ok) state_d = ST_CAPTURE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    assign capture_busy_out       = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
    assign capture_done_out       = (state_q == ST_DONE);
    assign ram_write_enable_out   = pending;
    assign read_request_ready_out = !pending;
    assign ram_address_out        = pending ? pending_addr
                                            : read_request_address_in[BYTE_ADDRESS_WIDTH-1:2];
    assign rd_accept              = read_request_valid_in && !pending;

    assign rd_lane_d = rd_accept ? read_request_address_in[1:0] : rd_lane_p0_q;
    assign rd_data_d = rd_vld_p0_q ? ram_read_data_in[{rd_lane_p0_q, 3'b000} +: 8] : rd_data_p1_q;

    // p0: request accepted, RAM addressed; p1: RAM word returned, byte lane registered out
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rd_vld_p0_q  <= 1'b0;
            rd_lane_p0_q <= 2'd0;
            rd_vld_p1_q  <= 1'b0;
            rd_data_p1_q <= 8'd0;
        end else begin
            rd_vld_p0_q  <= rd_accept;
            rd_lane_p0_q <= rd_lane_d;
            rd_vld_p1_q  <= rd_vld_p0_q;
            rd_data_p1_q <= rd_data_d;
        end
    end

    assign read_data_valid_out = rd_vld_p1_q;
    assign read_data_out       = rd_data_p1_q;

endmodule
